// File: rtl/vec_pkg.sv
// Shared vector-datapath types for the lane reducer: lane/vector geometry and FSM encoding.
package vec_pkg;

   localparam int unsigned VLANES  = 16;
   localparam int unsigned VLANE_W = 16;
   localparam int unsigned VEC_W   = VLANES * VLANE_W;

   typedef logic [VEC_W-1:0]          vec_t;
   typedef logic signed [VLANE_W-1:0] lane_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      OUTPUT = 2'd2
   } red_state_e;

endpackage

// File: rtl/sat_shift.sv
// Scales an accumulator down by an arithmetic right shift and saturates it to a signed lane.
// Optional round-half-up before the shift when VEC_LANE_REDUCER_ROUND_EN is defined.
module sat_shift #(
   parameter int unsigned ACC_W  = 40,
   parameter int unsigned LANE_W = 16,
   parameter int unsigned SHIFT  = 8
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic        [LANE_W-1:0] data,
   output logic                     sat
);

   // One guard bit so the rounding add can never wrap.
   localparam int unsigned EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((1 << (LANE_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

   logic signed [EXT_W-1:0] ext;
   logic signed [EXT_W-1:0] rnd;
   logic signed [EXT_W-1:0] shf;

   always_comb begin
      ext = {acc[ACC_W-1], acc};
`ifdef VEC_LANE_REDUCER_ROUND_EN
      rnd = ext + (EXT_W'(1) << (SHIFT - 1));
`else
      rnd = ext;
`endif
      shf = rnd >>> SHIFT;
      if (shf > MAX_V) begin
         data = {1'b0, {(LANE_W - 1){1'b1}}};
         sat  = 1'b1;
      end else if (shf < MIN_V) begin
         data = {1'b1, {(LANE_W - 1){1'b0}}};
         sat  = 1'b1;
      end else begin
         data = shf[LANE_W-1:0];
         sat  = 1'b0;
      end
   end

endmodule

// File: rtl/vec_lane_reducer.sv
// Reduces signed lanes of incoming vectors into an accumulator and emits one scaled, saturated
// sample per in_last-tagged vector. Rounding is enabled by VEC_LANE_REDUCER_ROUND_EN.
module vec_lane_reducer
   import vec_pkg::*;
#(
   parameter int unsigned LANES         = VLANES,
   parameter int unsigned LANE_W        = VLANE_W,
   parameter int unsigned LANES_PER_CYC = 4,
   parameter int unsigned ACC_W         = 40,
   parameter int unsigned SHIFT         = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*LANE_W-1:0]   in_vec,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANE_W-1:0]         out_data,
   output logic                      out_sat,
   output logic                      busy
);

   localparam int unsigned VW       = LANES * LANE_W;
   localparam int unsigned IDX_W    = $clog2(LANES) + 1;
   localparam int unsigned STEP_W   = LANES_PER_CYC * LANE_W;
   localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES_PER_CYC);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - LANES_PER_CYC);

   red_state_e              state_q, state_d;
   logic [VW-1:0]           vec_q, vec_d;
   logic                    last_q, last_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [LANE_W-1:0]       data_q, data_d;
   logic                    sat_q, sat_d;

   logic signed [ACC_W-1:0] psum;
   logic [LANE_W-1:0]       sat_data;
   logic                    sat_flag;
   lane_t                   lane;

   // The latched vector is shifted down each REDUCE cycle, so the active lanes are always lowest.
   always_comb begin
      psum = '0;
      lane = '0;
      for (int k = 0; k < int'(LANES_PER_CYC); k++) begin
         lane = lane_t'(vec_q[k*LANE_W +: LANE_W]);
         psum = psum + ACC_W'(lane);
      end
   end

   // Fed with the next accumulator value so the output is registered on entry to OUTPUT.
   sat_shift #(
      .ACC_W  (ACC_W),
      .LANE_W (LANE_W),
      .SHIFT  (SHIFT)
   ) u_sat_shift (
      .acc  (acc_d),
      .data (sat_data),
      .sat  (sat_flag)
   );

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      last_d  = last_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      data_d  = data_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               vec_d   = in_vec;
               last_d  = in_last;
               idx_d   = '0;
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            acc_d = acc_q + psum;
            vec_d = vec_q >> STEP_W;
            idx_d = idx_q + STEP;
            if (idx_q == LAST_IDX) begin
               if (last_q) begin
                  data_d  = sat_data;
                  sat_d   = sat_flag;
                  state_d = OUTPUT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               acc_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUTPUT);
   assign busy      = (state_q != IDLE);
   assign out_data  = data_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_vec_lane_reducer.sv
// Directed self-checking bench for vec_lane_reducer (default parameters).
module tb_vec_lane_reducer;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] in_vec;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic         out_sat;
   logic         busy;

   int checks;
   int failures;

`ifdef VEC_LANE_REDUCER_ROUND_EN
   localparam logic [15:0] RoundExp = 16'h0001;
`else
   localparam logic [15:0] RoundExp = 16'h0000;
`endif

   vec_lane_reducer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] fill(input logic [15:0] v);
      logic [255:0] r;
      for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
      return r;
   endfunction

   // Drive one vector at a negedge and hold it across the accepting posedge.
   task automatic accept_vec(input logic [255:0] v, input logic last);
      int n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
      end
      in_vec   = v;
      in_last  = last;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts negedges after the accept edge until out_valid; 99 on timeout.
   task automatic wait_out(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n == 0) n = 99;
   endtask

   task automatic ack_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks += 5;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
      if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_positive();
      int n;
      accept_vec(fill(16'h0100), 1'b1);
      wait_out(n);
      checks += 3;
      if (n != 5) begin failures++; $display("FAIL pos_latency: got %0d want 5", n); end
      if (out_data !== 16'h0010) begin failures++; $display("FAIL pos_data: got %h want 0010", out_data); end
      if (out_sat !== 1'b0) begin failures++; $display("FAIL pos_sat: got %b want 0", out_sat); end
      ack_out();
   endtask

   task automatic test_negative();
      int n;
      accept_vec(fill(16'hFF00), 1'b1);
      wait_out(n);
      checks += 2;
      if (out_data !== 16'hFFF0) begin failures++; $display("FAIL neg_data: got %h want fff0 (n=%0d)", out_data, n); end
      if (out_sat !== 1'b0) begin failures++; $display("FAIL neg_sat: got %b want 0", out_sat); end
      ack_out();
   endtask

   task automatic test_saturate_accum();
      int n;
      for (int v = 0; v < 20; v++) begin
         accept_vec(fill(16'h7FFF), (v == 19));
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL sat_reduce_ready: vec %0d cyc %0d got %b want 0", v, c, in_ready);
            end
         end
      end
      wait_out(n);
      checks += 2;
      if (out_data !== 16'h7FFF) begin failures++; $display("FAIL sat_data: got %h want 7fff (n=%0d)", out_data, n); end
      if (out_sat !== 1'b1) begin failures++; $display("FAIL sat_flag: got %b want 1", out_sat); end
      ack_out();
   endtask

   task automatic test_round();
      int n;
      logic [255:0] v;
      v = '0;
      v[15:0] = 16'h0080;
      accept_vec(v, 1'b1);
      wait_out(n);
      checks += 2;
      if (out_data !== RoundExp) begin failures++; $display("FAIL round_data: got %h want %h (n=%0d)", out_data, RoundExp, n); end
      if (out_sat !== 1'b0) begin failures++; $display("FAIL round_sat: got %b want 0", out_sat); end
      ack_out();
   endtask

   task automatic test_back_pressure();
      int n;
      accept_vec(fill(16'h0100), 1'b1);
      wait_out(n);
      // Upstream offers a vector during OUTPUT; it must be ignored.
      in_vec   = fill(16'h7FFF);
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks += 4;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: cyc %0d got %b want 1", c, out_valid); end
         if (out_data !== 16'h0010) begin failures++; $display("FAIL bp_data: cyc %0d got %h want 0010", c, out_data); end
         if (out_sat !== 1'b0) begin failures++; $display("FAIL bp_sat: cyc %0d got %b want 0", c, out_sat); end
         if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: cyc %0d got %b want 0", c, in_ready); end
      end
      in_vec    = fill(16'h0200);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks += 2;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL bp_next_accept: busy got %b want 1", busy); end
      wait_out(n);
      checks += 2;
      if (n != 5) begin failures++; $display("FAIL bp_next_latency: got %0d want 5", n); end
      if (out_data !== 16'h0020) begin failures++; $display("FAIL bp_next_data: got %h want 0020", out_data); end
      ack_out();
   endtask

   task automatic test_reset_mid_reduce();
      int n;
      accept_vec(fill(16'h7FFF), 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      accept_vec(fill(16'h0100), 1'b1);
      wait_out(n);
      checks += 2;
      if (out_data !== 16'h0010) begin failures++; $display("FAIL rst_mid_data: got %h want 0010 (n=%0d)", out_data, n); end
      if (out_sat !== 1'b0) begin failures++; $display("FAIL rst_mid_sat: got %b want 0", out_sat); end
      ack_out();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_vec    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_positive();
      test_negative();
      test_saturate_accum();
      test_round();
      test_back_pressure();
      test_reset_mid_reduce();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
